// File: rtl/chain_code_tracker_pkg.sv
// Shared types for the chain-code tracker: FSM states, Freeman code values,
// per-step perimeter weights and the code -> (dx,dy) lookup (y grows downward).
package chain_code_tracker_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TRACK  = 3'd1,
      ST_FINISH = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERR    = 3'd4
   } state_t;

   localparam logic [2:0] FC_E  = 3'd0;
   localparam logic [2:0] FC_NE = 3'd1;
   localparam logic [2:0] FC_N  = 3'd2;
   localparam logic [2:0] FC_NW = 3'd3;
   localparam logic [2:0] FC_W  = 3'd4;
   localparam logic [2:0] FC_SW = 3'd5;
   localparam logic [2:0] FC_S  = 3'd6;
   localparam logic [2:0] FC_SE = 3'd7;

   // Q8 weights: axial step = 1.0, diagonal step ~ sqrt(2)
   localparam int EVEN_W8 = 256;
   localparam int ODD_W8  = 362;

   typedef struct packed {
      logic signed [1:0] dx;
      logic signed [1:0] dy;
   } delta_t;

   function automatic delta_t code_delta(input logic [2:0] c);
      delta_t d;
      d.dx = 2'sb00;
      d.dy = 2'sb00;
      case (c)
         FC_E:  begin d.dx = 2'sb01; d.dy = 2'sb00; end
         FC_NE: begin d.dx = 2'sb01; d.dy = 2'sb11; end
         FC_N:  begin d.dx = 2'sb00; d.dy = 2'sb11; end
         FC_NW: begin d.dx = 2'sb11; d.dy = 2'sb11; end
         FC_W:  begin d.dx = 2'sb11; d.dy = 2'sb00; end
         FC_SW: begin d.dx = 2'sb11; d.dy = 2'sb01; end
         FC_S:  begin d.dx = 2'sb00; d.dy = 2'sb01; end
         FC_SE: begin d.dx = 2'sb01; d.dy = 2'sb01; end
         default: begin d.dx = 2'sb00; d.dy = 2'sb00; end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/chain_step_decoder.sv
// Combinational: Freeman code + current pixel -> next pixel, diagonal flag and
// image-edge violation flag. Zero latency, no flow control.
module chain_step_decoder
   import chain_code_tracker_pkg::*;
#(
   parameter int COORD_W = 6
) (
   input  logic [2:0]         code,
   input  logic [COORD_W-1:0] cur_x,
   input  logic [COORD_W-1:0] cur_y,
   output logic [COORD_W-1:0] nxt_x,
   output logic [COORD_W-1:0] nxt_y,
   output logic               is_odd,
   output logic               bound_err
);

   localparam logic [COORD_W-1:0] C_MAX = '1;

   delta_t d;
   logic   x_plus, x_minus, y_plus, y_minus;

   assign d       = code_delta(code);
   assign x_plus  = (d.dx == 2'sb01);
   assign x_minus = (d.dx == 2'sb11);
   assign y_plus  = (d.dy == 2'sb01);
   assign y_minus = (d.dy == 2'sb11);

   // Sign-extended delta add; wrap never reaches the registers because bound_err blocks it
   assign nxt_x = cur_x + {{(COORD_W-2){d.dx[1]}}, d.dx};
   assign nxt_y = cur_y + {{(COORD_W-2){d.dy[1]}}, d.dy};

   assign is_odd    = code[0];
   assign bound_err = (x_plus  && (cur_x == C_MAX)) ||
                      (x_minus && (cur_x == '0))    ||
                      (y_plus  && (cur_y == C_MAX)) ||
                      (y_minus && (cur_y == '0));

endmodule

// File: rtl/chain_code_tracker.sv
// Rebuilds contour pixels from a chain-code stream, tracks bbox/step counts/perimeter.
// One code per cycle, cur updates on the code edge; done 2 edges after the last code.
module chain_code_tracker
   import chain_code_tracker_pkg::*;
#(
   parameter int COORD_W = 6,
   parameter int CNT_W   = 8,
   parameter int PERIM_W = 17
) (
   input  logic               Clk,
   input  logic               reset,
   input  logic               start_valid,
   input  logic [COORD_W-1:0] start_x,
   input  logic [COORD_W-1:0] start_y,
   input  logic               code_valid,
   input  logic [2:0]         code,
   input  logic               code_last,
   input  logic               enc_error,
   output logic               busy,
   output logic [COORD_W-1:0] cur_x,
   output logic [COORD_W-1:0] cur_y,
   output logic [COORD_W-1:0] min_x,
   output logic [COORD_W-1:0] max_x,
   output logic [COORD_W-1:0] min_y,
   output logic [COORD_W-1:0] max_y,
   output logic [CNT_W-1:0]   even_cnt,
   output logic [CNT_W-1:0]   odd_cnt,
   output logic [PERIM_W-1:0] perim_q8,
   output logic               closed,
   output logic               done,
   output logic               error
);

   localparam logic [PERIM_W-1:0] EVEN_INC = PERIM_W'(EVEN_W8);
   localparam logic [PERIM_W-1:0] ODD_INC  = PERIM_W'(ODD_W8);

   state_t             state, state_nxt;
   logic [COORD_W-1:0] start_x_q, start_y_q;
   logic [COORD_W-1:0] nxt_x, nxt_y;
   logic               step_odd, bound_err;
   logic [CNT_W:0]     step_total;
   logic               cnt_full, step_err;
   logic               capture, go_err, do_step, finish;

   chain_step_decoder #(.COORD_W(COORD_W)) u_step (
      .code      (code),
      .cur_x     (cur_x),
      .cur_y     (cur_y),
      .nxt_x     (nxt_x),
      .nxt_y     (nxt_y),
      .is_odd    (step_odd),
      .bound_err (bound_err)
   );

   assign step_total = {1'b0, even_cnt} + {1'b0, odd_cnt};
   assign cnt_full   = (step_total == {1'b0, {CNT_W{1'b1}}});
   assign step_err   = bound_err || cnt_full;

   // enc_error outranks everything outside IDLE, including a re-arm from DONE
   assign capture = start_valid &&
                    ((state == ST_IDLE) || ((state == ST_DONE) && !enc_error));
   assign go_err  = (enc_error && (state != ST_IDLE) && (state != ST_ERR)) ||
                    ((state == ST_TRACK) && code_valid && step_err);
   assign do_step = (state == ST_TRACK) && code_valid && !enc_error && !step_err;
   assign finish  = (state == ST_FINISH) && !enc_error;

   always_ff @(posedge Clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (capture) state_nxt = ST_TRACK;
         ST_TRACK: begin
            if (go_err)                    state_nxt = ST_ERR;
            else if (do_step && code_last) state_nxt = ST_FINISH;
         end
         ST_FINISH: state_nxt = go_err ? ST_ERR : ST_DONE;
         ST_DONE: begin
            if (go_err)       state_nxt = ST_ERR;
            else if (capture) state_nxt = ST_TRACK;
         end
         ST_ERR:    state_nxt = ST_ERR;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      case (state)
         ST_TRACK, ST_FINISH: busy = 1'b1;
         default:             busy = 1'b0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         start_x_q <= '0;
         start_y_q <= '0;
         cur_x     <= '0;
         cur_y     <= '0;
         min_x     <= '0;
         max_x     <= '0;
         min_y     <= '0;
         max_y     <= '0;
         even_cnt  <= '0;
         odd_cnt   <= '0;
         perim_q8  <= '0;
         closed    <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else if (capture) begin
         start_x_q <= start_x;
         start_y_q <= start_y;
         cur_x     <= start_x;
         cur_y     <= start_y;
         min_x     <= start_x;
         max_x     <= start_x;
         min_y     <= start_y;
         max_y     <= start_y;
         even_cnt  <= '0;
         odd_cnt   <= '0;
         perim_q8  <= '0;
         closed    <= 1'b0;
         done      <= 1'b0;
      end else if (go_err) begin
         error  <= 1'b1;
         done   <= 1'b1;
         closed <= 1'b0;
      end else if (do_step) begin
         cur_x <= nxt_x;
         cur_y <= nxt_y;
         if (nxt_x < min_x) min_x <= nxt_x;
         if (nxt_x > max_x) max_x <= nxt_x;
         if (nxt_y < min_y) min_y <= nxt_y;
         if (nxt_y > max_y) max_y <= nxt_y;
         if (step_odd) begin
            odd_cnt  <= odd_cnt + 1'b1;
            perim_q8 <= perim_q8 + ODD_INC;
         end else begin
            even_cnt <= even_cnt + 1'b1;
            perim_q8 <= perim_q8 + EVEN_INC;
         end
      end else if (finish) begin
         closed <= (cur_x == start_x_q) && (cur_y == start_y_q);
         done   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_chain_code_tracker.sv
// Bench for chain_code_tracker: directed contour table, hand-written corner
// sequences and random contours checked against a coordinate-level model.
module tb_chain_code_tracker;

   localparam int CW   = 6;
   localparam int NW   = 8;
   localparam int PW   = 17;
   localparam int CMAX = (1 << CW) - 1;
   localparam int NMAX = (1 << NW) - 1;

   logic          Clk = 1'b0;
   logic          reset = 1'b1;
   logic          start_valid = 1'b0;
   logic [CW-1:0] start_x = '0, start_y = '0;
   logic          code_valid = 1'b0;
   logic [2:0]    code = '0;
   logic          code_last = 1'b0;
   logic          enc_error = 1'b0;
   logic          busy;
   logic [CW-1:0] cur_x, cur_y, min_x, max_x, min_y, max_y;
   logic [NW-1:0] even_cnt, odd_cnt;
   logic [PW-1:0] perim_q8;
   logic          closed, done, error;

   chain_code_tracker #(.COORD_W(CW), .CNT_W(NW), .PERIM_W(PW)) dut (
      .Clk(Clk), .reset(reset), .start_valid(start_valid),
      .start_x(start_x), .start_y(start_y), .code_valid(code_valid),
      .code(code), .code_last(code_last), .enc_error(enc_error),
      .busy(busy), .cur_x(cur_x), .cur_y(cur_y),
      .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
      .even_cnt(even_cnt), .odd_cnt(odd_cnt), .perim_q8(perim_q8),
      .closed(closed), .done(done), .error(error)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int cx, cy, mnx, mxx, mny, mxy, ev, od, perim, closed, err;
   } res_t;

   typedef struct {
      int          sx, sy, n;
      logic [23:0] codes;
      res_t        exp;
   } vec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   code_q[$];
   int   dxs[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
   int   dys[8] = '{0, -1, -1, -1, 0, 1, 1, 1};
   vec_t tbl[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic res_t mk(input int cx, cy, mnx, mxx, mny, mxy, ev, od, perim, cl, err);
      res_t r;
      r.cx = cx; r.cy = cy; r.mnx = mnx; r.mxx = mxx; r.mny = mny; r.mxy = mxy;
      r.ev = ev; r.od = od; r.perim = perim; r.closed = cl; r.err = err;
      return r;
   endfunction

   function automatic vec_t mkv(input int sx, sy, n, input logic [23:0] codes, input res_t e);
      vec_t v;
      v.sx = sx; v.sy = sy; v.n = n; v.codes = codes; v.exp = e;
      return v;
   endfunction

   // Walk the pixel grid directly; a step leaving the image or exceeding the step limit kills the contour
   task automatic model(input int sx, input int sy, output res_t r);
      int x, y, nx, ny;
      x = sx; y = sy;
      r = mk(sx, sy, sx, sx, sy, sy, 0, 0, 0, 0, 0);
      foreach (code_q[i]) begin
         if (r.err == 0) begin
            nx = x + dxs[code_q[i]];
            ny = y + dys[code_q[i]];
            if (nx < 0 || nx > CMAX || ny < 0 || ny > CMAX || r.ev + r.od == NMAX) begin
               r.err = 1;
            end else begin
               x = nx; y = ny;
               if (code_q[i] % 2 == 1) r.od++; else r.ev++;
               if (x < r.mnx) r.mnx = x;
               if (x > r.mxx) r.mxx = x;
               if (y < r.mny) r.mny = y;
               if (y > r.mxy) r.mxy = y;
            end
         end
      end
      r.cx = x; r.cy = y;
      r.perim  = r.ev * 256 + r.od * 362;
      r.closed = (r.err == 0 && x == sx && y == sy) ? 1 : 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge Clk);
      reset = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".cur_x"},   32'(cur_x), 0);
      check({tag, ".cur_y"},   32'(cur_y), 0);
      check({tag, ".min_x"},   32'(min_x), 0);
      check({tag, ".max_y"},   32'(max_y), 0);
      check({tag, ".even"},    32'(even_cnt), 0);
      check({tag, ".odd"},     32'(odd_cnt), 0);
      check({tag, ".perim"},   32'(perim_q8), 0);
      check({tag, ".closed"},  32'(closed), 0);
      check({tag, ".done"},    32'(done), 0);
      check({tag, ".error"},   32'(error), 0);
      check({tag, ".busy"},    32'(busy), 0);
   endtask

   task automatic check_res(input string tag, input res_t e);
      check({tag, ".cur_x"},  32'(cur_x), e.cx);
      check({tag, ".cur_y"},  32'(cur_y), e.cy);
      check({tag, ".min_x"},  32'(min_x), e.mnx);
      check({tag, ".max_x"},  32'(max_x), e.mxx);
      check({tag, ".min_y"},  32'(min_y), e.mny);
      check({tag, ".max_y"},  32'(max_y), e.mxy);
      check({tag, ".even"},   32'(even_cnt), e.ev);
      check({tag, ".odd"},    32'(odd_cnt), e.od);
      check({tag, ".perim"},  32'(perim_q8), e.perim);
      check({tag, ".closed"}, 32'(closed), e.closed);
      check({tag, ".error"},  32'(error), e.err);
      check({tag, ".done"},   32'(done), 1);
      check({tag, ".busy"},   32'(busy), 0);
   endtask

   // Start, stream code_q, then check; errored contours are followed by a reset
   task automatic run_contour(input int sx, input int sy, input res_t e, input string tag);
      start_x = CW'(sx); start_y = CW'(sy); start_valid = 1'b1;
      @(negedge Clk);
      start_valid = 1'b0;
      check({tag, ".busy_start"}, 32'(busy), 1);
      check({tag, ".done_start"}, 32'(done), 0);
      foreach (code_q[i]) begin
         code_valid = 1'b1;
         code       = 3'(code_q[i]);
         code_last  = (i == code_q.size() - 1);
         @(negedge Clk);
         code_valid = 1'b0;
         code_last  = 1'b0;
      end
      if (e.err == 0) begin
         check({tag, ".done_1edge"}, 32'(done), 0);
         @(negedge Clk);
      end
      check_res(tag, e);
      if (e.err != 0) do_reset();
   endtask

   initial begin
      res_t e;
      int   k, c;
      int   path[$];

      tbl[0] = mkv(10, 10, 4, {3'd2, 3'd4, 3'd6, 3'd0}, mk(10, 10, 10, 11, 10, 11, 4, 0, 1024, 1, 0));
      tbl[1] = mkv(20,  5, 4, {3'd1, 3'd3, 3'd5, 3'd7}, mk(20, 5, 19, 21, 5, 7, 0, 4, 1448, 1, 0));
      tbl[2] = mkv( 5,  5, 2, {3'd0, 3'd0},             mk(7, 5, 5, 7, 5, 5, 2, 0, 512, 0, 0));
      tbl[3] = mkv(63,  0, 3, {3'd6, 3'd4, 3'd0},       mk(63, 0, 63, 63, 0, 0, 0, 0, 0, 0, 1));
      tbl[4] = mkv( 0,  0, 4, {3'd4, 3'd4, 3'd0, 3'd6}, mk(0, 1, 0, 1, 0, 1, 3, 0, 768, 0, 1));
      tbl[5] = mkv(62, 62, 2, {3'd1, 3'd7},             mk(63, 63, 62, 63, 62, 63, 0, 1, 362, 0, 1));
      tbl[6] = mkv( 0, 63, 1, {3'd6},                   mk(0, 63, 0, 0, 63, 63, 0, 0, 0, 0, 1));

      repeat (2) @(negedge Clk);
      reset = 1'b0;
      check_zero("reset");

      foreach (tbl[i]) begin
         code_q.delete();
         for (int j = 0; j < tbl[i].n; j++) code_q.push_back(int'(tbl[i].codes[3*j +: 3]));
         run_contour(tbl[i].sx, tbl[i].sy, tbl[i].exp, $sformatf("vec%0d", i));
      end

      // Reset in the middle of a contour, then a clean contour
      start_x = 6'd30; start_y = 6'd30; start_valid = 1'b1;
      @(negedge Clk);
      start_valid = 1'b0;
      code_valid = 1'b1; code = 3'd0;
      repeat (2) @(negedge Clk);
      code_valid = 1'b0;
      do_reset();
      check_zero("midreset");
      code_q = '{6, 2};
      run_contour(1, 1, mk(1, 1, 1, 1, 1, 2, 2, 0, 512, 1, 0), "after_reset");

      // Encoder error while tracking; later codes must be ignored
      start_x = 6'd8; start_y = 6'd8; start_valid = 1'b1;
      @(negedge Clk);
      start_valid = 1'b0;
      code_valid = 1'b1; code = 3'd0;
      @(negedge Clk);
      code_valid = 1'b0; enc_error = 1'b1;
      @(negedge Clk);
      enc_error = 1'b0;
      check("encerr.error",  32'(error), 1);
      check("encerr.done",   32'(done), 1);
      check("encerr.busy",   32'(busy), 0);
      check("encerr.closed", 32'(closed), 0);
      code_valid = 1'b1; code = 3'd0; code_last = 1'b1;
      @(negedge Clk);
      code_valid = 1'b0; code_last = 1'b0;
      check("encerr.cur_x_frozen", 32'(cur_x), 9);
      check("encerr.even_frozen",  32'(even_cnt), 1);
      do_reset();

      // Start and code in the same IDLE cycle: code dropped
      start_x = 6'd4; start_y = 6'd4; start_valid = 1'b1;
      code_valid = 1'b1; code = 3'd0; code_last = 1'b1;
      @(negedge Clk);
      start_valid = 1'b0; code_valid = 1'b0; code_last = 1'b0;
      check("samecyc.even", 32'(even_cnt), 0);
      check("samecyc.cur_x", 32'(cur_x), 4);
      check("samecyc.busy", 32'(busy), 1);
      code_valid = 1'b1; code = 3'd0; code_last = 1'b1;
      @(negedge Clk);
      code_valid = 1'b0; code_last = 1'b0;
      @(negedge Clk);
      check("samecyc.done", 32'(done), 1);
      check("samecyc.cur_x_end", 32'(cur_x), 5);
      check("samecyc.even_end", 32'(even_cnt), 1);

      // Step-count limit: 255 steps accepted, the 256th is an error
      code_q.delete();
      for (int i = 0; i < NMAX; i++) code_q.push_back((i % 2 == 0) ? 0 : 4);
      code_q.push_back(0);
      model(10, 10, e);
      check("limit.model_even", 32'(e.ev), NMAX);
      run_contour(10, 10, e, "limit");

      // Random contours; odd iterations retrace their path so they close
      for (int it = 0; it < 60; it++) begin
         code_q.delete();
         path.delete();
         k = $urandom_range(1, 6);
         for (int j = 0; j < k; j++) begin
            c = $urandom_range(0, 7);
            code_q.push_back(c);
            path.push_front((c + 4) % 8);
         end
         if (it % 2 == 1) foreach (path[j]) code_q.push_back(path[j]);
         begin
            int sx, sy;
            sx = $urandom_range(0, CMAX);
            sy = $urandom_range(0, CMAX);
            model(sx, sy, e);
            run_contour(sx, sy, e, $sformatf("rand%0d", it));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
